// File: rtl/mic_buf_readout_ctrl.sv
// Readout scheduler for per-channel ping-pong mic buffers: walks all channels' completed
// buffers channel-major and streams samples over valid/ready. Define MIC_READOUT_HDR_EN for a per-frame header beat.
module mic_buf_readout_ctrl #(
  parameter int N_MICS          = 1,
  parameter int DATA_WIDTH      = 16,
  parameter int SAMPLES_PER_BUF = 256,
  parameter int ADDR_WIDTH      = $clog2(SAMPLES_PER_BUF),
  parameter int CH_W            = $clog2(N_MICS > 1 ? N_MICS : 2)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              buf_ready_pulse_i,
  output logic [ADDR_WIDTH-1:0]             rd_addr_o,
  output logic [N_MICS-1:0]                 rd_en_o,
  input  logic [N_MICS-1:0][DATA_WIDTH-1:0] rd_data_i,
  input  logic [N_MICS-1:0]                 rd_data_valid_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [DATA_WIDTH-1:0]             out_data_o,
  output logic [CH_W-1:0]                   out_ch_o,
  output logic [ADDR_WIDTH-1:0]             out_idx_o,
  output logic                              out_last_o,
  output logic                              out_hdr_o,
  output logic                              busy_o,
  output logic                              overrun_o,
  input  logic                              overrun_clr_i
);

`ifdef MIC_READOUT_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SAMPLES_PER_BUF - 1);
  localparam logic [CH_W-1:0]       LAST_CH   = CH_W'(N_MICS - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_ISSUE, S_DRAIN} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [CH_W-1:0]       ch;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  last;
    logic                  hdr;
  } beat_t;

  state_e                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  inflight_q, inflight_d;
  logic [CH_W-1:0]       if_ch_q, if_ch_d;
  logic [ADDR_WIDTH-1:0] if_idx_q, if_idx_d;
  logic                  if_last_q, if_last_d;
  beat_t                 fifo_q [2];
  beat_t                 fifo_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic                  last_done_q, last_done_d;
  logic [DATA_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

  beat_t                 head;
  beat_t                 push_beat;
  logic                  push, pop, issue, start, ret_valid;
  logic [2:0]            occ;
  logic [DATA_WIDTH-1:0] ret_data;
  logic [N_MICS-1:0]     if_mask;

  // Handshake: a beat moves on a cycle where out_valid_o && out_ready_i; while valid is
  // high and ready is low the head entry, and therefore every out_* field, is held.
  assign head        = fifo_q[rd_ptr_q];
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = head.data;
  assign out_ch_o    = head.ch;
  assign out_idx_o   = head.idx;
  assign out_last_o  = head.last;
  assign out_hdr_o   = head.hdr;
  assign busy_o      = busy_q;
  assign overrun_o   = overrun_q;
  assign rd_addr_o   = addr_q;

  always_comb begin
    pop   = out_valid_o && out_ready_i;
    start = buf_ready_pulse_i && (state_q == S_IDLE);
    // The head counts as free when it leaves this cycle, so reads keep pace at one beat per cycle.
    occ   = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};
    issue = (state_q == S_ISSUE) && !rst_i && (occ < 3'd2);

    rd_en_o   = '0;
    ret_data  = '0;
    ret_valid = 1'b0;
    if_mask   = '0;
    for (int i = 0; i < N_MICS; i++) begin
      rd_en_o[i] = issue && (ch_q == CH_W'(i));
      if (if_ch_q == CH_W'(i)) begin
        ret_data   = rd_data_i[i];
        ret_valid  = inflight_q && rd_data_valid_i[i];
        if_mask[i] = inflight_q;
      end
    end

    push_beat = '0;
    push      = 1'b0;
    if (start && HDR_EN) begin
      push           = 1'b1;
      push_beat.data = frame_cnt_q;
      push_beat.hdr  = 1'b1;
    end else if (ret_valid) begin
      push           = 1'b1;
      push_beat.data = ret_data;
      push_beat.ch   = if_ch_q;
      push_beat.idx  = if_idx_q;
      push_beat.last = if_last_q;
    end

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = push_beat;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    inflight_d = issue;
    if_ch_d    = issue ? ch_q : if_ch_q;
    if_idx_d   = issue ? addr_q : if_idx_q;
    if_last_d  = issue ? ((ch_q == LAST_CH) && (addr_q == LAST_ADDR)) : if_last_q;

    frame_cnt_d = frame_cnt_q;
    last_done_d = last_done_q;
    if (pop && head.last) begin
      frame_cnt_d = frame_cnt_q + DATA_WIDTH'(1);
      last_done_d = 1'b1;
    end

    overrun_d = overrun_q;
    if (buf_ready_pulse_i && busy_q) overrun_d = 1'b1;
    else if (overrun_clr_i)          overrun_d = 1'b0;

    state_d = state_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = HDR_EN ? S_HDR : S_ISSUE;
          ch_d        = '0;
          addr_d      = '0;
          busy_d      = 1'b1;
          last_done_d = 1'b0;
        end
      end
      S_HDR: begin
        if (pop) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (issue) begin
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            if (ch_q == LAST_CH) state_d = S_DRAIN;
            else                 ch_d    = ch_q + CH_W'(1);
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if ((count_q == 2'd0) && !inflight_q && last_done_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      if_ch_q     <= '0;
      if_idx_q    <= '0;
      if_last_q   <= 1'b0;
      fifo_q      <= '{default: '0};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      last_done_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      addr_q      <= addr_d;
      inflight_q  <= inflight_d;
      if_ch_q     <= if_ch_d;
      if_idx_q    <= if_idx_d;
      if_last_q   <= if_last_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      last_done_q <= last_done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  a_rd_en_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rd_en_o));
  a_no_push_full:  assert property (@(posedge clk_i) disable iff (rst_i) push |-> (count_q != 2'd2));
  a_valid_matches: assert property (@(posedge clk_i) disable iff (rst_i)
                                    ((rd_data_valid_i & ~if_mask) == '0));

endmodule

// File: tb/tb_mic_buf_readout_ctrl.sv
// Bench for mic_buf_readout_ctrl: 2-mic/4-sample instance plus a 1-mic/2-sample instance,
// behavioural RAMs with one-cycle read latency, and an expected-beat queue.
module tb_mic_buf_readout_ctrl;
  localparam int NM  = 2;
  localparam int DW  = 16;
  localparam int SPB = 4;
  localparam int AW  = 2;
  localparam int CW  = 1;
  localparam int BW  = DW + CW + AW + 2;
`ifdef MIC_READOUT_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                   rst_i = 1'b1;
  logic                   buf_ready_pulse_i = 1'b0;
  logic [AW-1:0]          rd_addr_o;
  logic [NM-1:0]          rd_en_o;
  logic [NM-1:0][DW-1:0]  rd_data;
  logic [NM-1:0]          ram_valid;
  logic                   out_valid_o;
  logic                   out_ready_i = 1'b1;
  logic [DW-1:0]          out_data_o;
  logic [CW-1:0]          out_ch_o;
  logic [AW-1:0]          out_idx_o;
  logic                   out_last_o, out_hdr_o, busy_o, overrun_o;
  logic                   overrun_clr_i = 1'b0;

  logic                   b_pulse = 1'b0;
  logic [0:0]             b_rd_addr;
  logic [0:0]             b_rd_en;
  logic [0:0][DW-1:0]     b_rd_data;
  logic [0:0]             b_ram_valid;
  logic                   b_out_valid;
  logic                   b_out_ready = 1'b1;
  logic [DW-1:0]          b_out_data;
  logic [0:0]             b_out_ch;
  logic [0:0]             b_out_idx;
  logic                   b_out_last, b_out_hdr, b_busy, b_overrun;

  mic_buf_readout_ctrl #(.N_MICS(NM), .DATA_WIDTH(DW), .SAMPLES_PER_BUF(SPB)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .buf_ready_pulse_i(buf_ready_pulse_i),
    .rd_addr_o(rd_addr_o), .rd_en_o(rd_en_o), .rd_data_i(rd_data), .rd_data_valid_i(ram_valid),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_ch_o(out_ch_o), .out_idx_o(out_idx_o), .out_last_o(out_last_o), .out_hdr_o(out_hdr_o),
    .busy_o(busy_o), .overrun_o(overrun_o), .overrun_clr_i(overrun_clr_i));

  mic_buf_readout_ctrl #(.N_MICS(1), .DATA_WIDTH(DW), .SAMPLES_PER_BUF(2)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .buf_ready_pulse_i(b_pulse),
    .rd_addr_o(b_rd_addr), .rd_en_o(b_rd_en), .rd_data_i(b_rd_data), .rd_data_valid_i(b_ram_valid),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .out_ch_o(b_out_ch), .out_idx_o(b_out_idx), .out_last_o(b_out_last), .out_hdr_o(b_out_hdr),
    .busy_o(b_busy), .overrun_o(b_overrun), .overrun_clr_i(1'b0));

  // Buffer RAMs: channel c holds (c+1)*0x100 + index; data returns one cycle after rd_en.
  always @(posedge clk_i) begin
    ram_valid   <= rst_i ? '0 : rd_en_o;
    b_ram_valid <= rst_i ? '0 : b_rd_en;
    for (int c = 0; c < NM; c++) rd_data[c] <= DW'((c + 1) * 256) + DW'(rd_addr_o);
    b_rd_data[0] <= DW'(256) + DW'(b_rd_addr);
  end

  int n_chk = 0;
  int n_fail = 0;
  int beats_seen = 0;
  int b_beats = 0;
  int model_frames = 0;
  int occ = 0;
  logic hold_v = 1'b0;
  logic [BW-1:0] held;
  logic [BW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] pack(input logic [DW-1:0] d, input logic [CW-1:0] c,
                                         input logic [AW-1:0] i, input logic l, input logic h);
    return {d, c, i, l, h};
  endfunction

  task automatic push_frame();
    if (HDR != 0) exp_q.push_back(pack(DW'(model_frames), 1'b0, 2'd0, 1'b0, 1'b1));
    for (int c = 0; c < NM; c++)
      for (int i = 0; i < SPB; i++)
        exp_q.push_back(pack(DW'((c + 1) * 256 + i), CW'(c), AW'(i),
                             (c == NM - 1) && (i == SPB - 1), 1'b0));
    model_frames++;
  endtask

  task automatic pulse_a();
    @(posedge clk_i); #1 buf_ready_pulse_i = 1'b1;
    @(posedge clk_i); #1 buf_ready_pulse_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy_o && n < 300) begin @(posedge clk_i); #1; n++; end
    chk(nm, busy_o, 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rd_en"}, rd_en_o, 0);
    chk({nm, "_rd_addr"}, rd_addr_o, 0);
    chk({nm, "_valid"}, out_valid_o, 0);
    chk({nm, "_data"}, out_data_o, 0);
    chk({nm, "_ch"}, out_ch_o, 0);
    chk({nm, "_idx"}, out_idx_o, 0);
    chk({nm, "_last"}, out_last_o, 0);
    chk({nm, "_hdr"}, out_hdr_o, 0);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_overrun"}, overrun_o, 0);
  endtask

  // Monitor: scoreboard pops, stall stability, and read-issue room against observed occupancy.
  always @(negedge clk_i) begin
    logic pop;
    logic [BW-1:0] got;
    if (rst_i) begin
      occ = 0;
      hold_v = 1'b0;
    end else begin
      pop = out_valid_o && out_ready_i;
      got = pack(out_data_o, out_ch_o, out_idx_o, out_last_o, out_hdr_o);
      if (hold_v) begin
        chk("stall_valid", out_valid_o, 1);
        chk("stall_fields", got, held);
      end
      hold_v = out_valid_o && !out_ready_i;
      held = got;
      if (rd_en_o != '0) chk("issue_room", (occ - int'(pop) + int'(ram_valid != '0)) < 2, 1);
      occ = occ + int'(ram_valid != '0) - int'(pop);
      if (pop) begin
        beats_seen++;
        if (exp_q.size() == 0) chk("unexpected_beat", got, 0);
        else chk("beat", got, exp_q.pop_front());
      end
    end
    if (!rst_i && b_out_valid && b_out_ready) b_beats++;
  end

  typedef struct {
    logic          busy;
    logic [NM-1:0] rd_en;
    logic [AW-1:0] rd_addr;
    logic          valid;
    logic [DW-1:0] data;
    logic [CW-1:0] ch;
    logic [AW-1:0] idx;
    logic          last;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int base, n, k, b_base;
    for (int r = 0; r < 13; r++) begin
      k = (r >= 3) ? r - 3 : 0;
      tbl[r].busy    = (r >= 1) && (r <= 11);
      tbl[r].rd_en   = ((r >= 1) && (r <= 8)) ? NM'(1 << ((r - 1) / SPB)) : '0;
      tbl[r].rd_addr = (r >= 1) ? AW'((r - 1) % SPB) : '0;
      tbl[r].valid   = (r >= 3) && (r <= 10);
      tbl[r].data    = DW'((k / SPB + 1) * 256 + k % SPB);
      tbl[r].ch      = CW'(k / SPB);
      tbl[r].idx     = AW'(k % SPB);
      tbl[r].last    = (k == NM * SPB - 1);
    end

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk_zero("reset");

`ifndef MIC_READOUT_HDR_EN
    // Back-to-back frame with ready held high, cycle by cycle from the pulse.
    push_frame();
    @(posedge clk_i); #1 buf_ready_pulse_i = 1'b1;
    for (int r = 0; r < 13; r++) begin
      @(negedge clk_i);
      chk("t1_busy", busy_o, tbl[r].busy);
      chk("t1_rd_en", rd_en_o, tbl[r].rd_en);
      if (tbl[r].rd_en != '0) chk("t1_rd_addr", rd_addr_o, tbl[r].rd_addr);
      chk("t1_valid", out_valid_o, tbl[r].valid);
      if (tbl[r].valid) begin
        chk("t1_data", out_data_o, tbl[r].data);
        chk("t1_ch", out_ch_o, tbl[r].ch);
        chk("t1_idx", out_idx_o, tbl[r].idx);
        chk("t1_last", out_last_o, tbl[r].last);
      end
      @(posedge clk_i); #1 buf_ready_pulse_i = 1'b0;
    end
    chk("t1_queue", exp_q.size(), 0);

    // Ready toggling 1,0,1,0.
    base = beats_seen;
    push_frame();
    @(posedge clk_i); #1 buf_ready_pulse_i = 1'b1;
    @(posedge clk_i); #1 buf_ready_pulse_i = 1'b0; out_ready_i = 1'b0;
    n = 0;
    while (busy_o && n < 300) begin
      @(posedge clk_i); #1 out_ready_i = ~out_ready_i; n++;
    end
    out_ready_i = 1'b1;
    chk("t2_idle", busy_o, 0);
    chk("t2_beats", beats_seen - base, NM * SPB);
    chk("t2_queue", exp_q.size(), 0);

    // Overrun while busy, set-beats-clear, then a later clear.
    base = beats_seen;
    push_frame();
    @(posedge clk_i); #1 buf_ready_pulse_i = 1'b1;
    @(posedge clk_i); #1 buf_ready_pulse_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end
    buf_ready_pulse_i = 1'b1;
    @(negedge clk_i); chk("t3_ovr_before", overrun_o, 0);
    @(posedge clk_i); #1 buf_ready_pulse_i = 1'b0;
    @(negedge clk_i); chk("t3_ovr_set", overrun_o, 1);
    @(posedge clk_i); #1 buf_ready_pulse_i = 1'b1; overrun_clr_i = 1'b1;
    @(posedge clk_i); #1 buf_ready_pulse_i = 1'b0; overrun_clr_i = 1'b0;
    @(negedge clk_i); chk("t3_set_wins", overrun_o, 1);
    wait_idle("t3_idle");
    chk("t3_beats", beats_seen - base, NM * SPB);
    chk("t3_queue", exp_q.size(), 0);
    repeat (5) @(posedge clk_i);
    #1 overrun_clr_i = 1'b1;
    @(negedge clk_i); chk("t3_ovr_hold", overrun_o, 1);
    @(posedge clk_i); #1 overrun_clr_i = 1'b0;
    @(negedge clk_i); chk("t3_ovr_clr", overrun_o, 0);
    chk("t3_no_restart", busy_o, 0);

    // Reset one cycle after the third beat aborts the frame.
    base = beats_seen;
    push_frame();
    pulse_a();
    n = 0;
    while (beats_seen < base + 3 && n < 50) begin @(negedge clk_i); #1; n++; end
    chk("t4_third_beat", beats_seen - base, 3);
    @(posedge clk_i); #1 rst_i = 1'b1; exp_q.delete();
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk_zero("t4_after_rst");
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    chk("t4_no_beats", beats_seen - base, 3);
    chk("t4_quiet_valid", out_valid_o, 0);
    push_frame();
    pulse_a();
    wait_idle("t4_idle");
    chk("t4_restart_beats", beats_seen - base, 3 + NM * SPB);
    chk("t4_queue", exp_q.size(), 0);
`else
    // Three frames, each led by a header carrying the frame count.
    base = beats_seen;
    for (int f = 0; f < 3; f++) begin
      push_frame();
      pulse_a();
      wait_idle("t5_idle");
    end
    chk("t5_beats", beats_seen - base, 3 * (NM * SPB + 1));
    chk("t5_queue", exp_q.size(), 0);
`endif

    // Pulse coinciding with the last handshake of the 1-mic instance is an overrun.
    b_base = b_beats;
    @(posedge clk_i); #1 b_pulse = 1'b1;
    @(posedge clk_i); #1 b_pulse = 1'b0;
    repeat (3 + HDR) begin @(posedge clk_i); #1; end
    b_pulse = 1'b1;
    @(negedge clk_i);
    chk("t6_last_hs", b_out_valid && b_out_last && b_out_ready, 1);
    chk("t6_last_data", b_out_data, 16'h101);
    @(posedge clk_i); #1 b_pulse = 1'b0;
    @(negedge clk_i); chk("t6_overrun", b_overrun, 1);
    repeat (8) @(posedge clk_i);
    @(negedge clk_i); #1;
    chk("t6_idle", b_busy, 0);
    chk("t6_no_valid", b_out_valid, 0);
    chk("t6_beats", b_beats - b_base, 2 + HDR);

    chk("final_queue", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
